n64_controller_responder: RTL and testbench
===========================================

// Module: n64_controller_responder
// PURPOSE
// Controller-side end of the N64 single-wire serial link: emulates a controller answering the console/host.
// Decodes the host's 8-bit command plus its stop bit, then replies with ID or button status.
// Sits between the open-drain data pad (sampled input, pull-low enable output) and button-scanning logic.
// PARAMETERS
// CLKS_PER_US  50  clk cycles per microsecond (50 MHz); all protocol timing is derived from it, min 4
// TIMEOUT_US   8    max low or high time inside a command before abort
// TURN_US      2    delay from end of host stop bit to first reply bit
// PORTS
// clk             in   1   system clock, rising edge
// Reset           in   1   asynchronous, active-low reset
// Data_In         in   1   raw pad level (async); 1 = line released/high
// Data_Out_Low    out  1   1 = drive line low (open-drain enable), 0 = release
// Buttons         in   32  status word {A,B,Z,St,Du,Dd,Dl,Dr,rsv,rsv,L,R,Cu,Cd,Cl,Cr,X[7:0],Y[7:0]}
// Cmd             out  8   last command received; valid while Cmd_Valid
// Cmd_Valid       out  1   one-cycle pulse when command+stop decoded
// Busy            out  1   high from first command falling edge until reply stop bit released
// Error           out  1   one-cycle pulse on timeout/abort
// BEHAVIOUR
// - Reset (async assert, sync deassert use): all outputs 0, state IDLE, counters 0, Cmd=8'h00.
// - Data_In passes 2-flop synchronizer; all decode uses synced value s (2-cycle latency). Edges detected on s.
// - Bit cell = 4us. Host/reply '0' = 3us low + 1us high; '1' = 1us low + 3us high. MSB first.
// - States: IDLE, RX_LOW, RX_HIGH, RX_STOP, TURN, TX_BIT, TX_STOP.
// - IDLE: s falling edge -> RX_LOW, bit counter=0, Busy=1, timer=0.
// - RX_LOW: at timer == 2*CLKS_PER_US sample s into shift reg (1 if high). s rising -> RX_HIGH.
//   bitcnt increments on sample; low exceeding TIMEOUT_US -> Error pulse, IDLE.
// - A rising edge before the 2us sample still samples at 2us (value 1). No early-edge special case.
// - RX_HIGH: next falling edge -> RX_LOW if bitcnt<8, else RX_STOP.
//   High exceeding TIMEOUT_US -> Error pulse, IDLE.
// - RX_STOP: on s rising edge (host stop released) Cmd<=shift, Cmd_Valid pulse same cycle.
//   Cmd 8'h00 or 8'hFF -> reply 24'h050002 (24 bits); 8'h01 -> reply Buttons (32 bits).
//   Any other -> no reply, Busy=0, IDLE (not an Error). Stop low > TIMEOUT_US -> Error, IDLE.
// - TURN: wait TURN_US*CLKS_PER_US cycles, line released. Buttons snapshot taken on entry to TURN.
//   Buttons changes after that do not affect the current reply.
// - TX_BIT: per bit, Data_Out_Low=1 for 1us ('1') or 3us ('0'), then 0 until 4us cell end.
//   No gap between cells. Input ignored during TX states.
// - TX_STOP: after last bit, Data_Out_Low=1 for 2us, then release. Busy=0 one cycle later; IDLE.
//   A new falling edge is only accepted after return to IDLE.
// - Reset mid-reply releases line immediately (Data_Out_Low=0 asynchronously).
// - Timer width $clog2(TIMEOUT_US*CLKS_PER_US+1); timer saturates, never wraps.
// - Data_Out_Low is registered; line never driven outside TX_BIT/TX_STOP.
// TESTING (CLKS_PER_US=4 for sim)
// - Host sends 8'h01 + stop, Buttons=32'h8000_7F80 -> Cmd_Valid with Cmd=01; after 2us,
//   32 reply cells decode to 80007F80, then 2us low stop, Busy falls.
// - Host sends 8'h00 -> reply decodes 24'h050002.
// - Host sends 8'hFF -> reply decodes 24'h050002.
// - Host sends 8'h40 -> Cmd_Valid, Cmd=40, no Data_Out_Low activity; Busy=0 within 2 cycles.
// - Host stops after 5 bits, line high 10us -> Error pulse once, IDLE, Data_Out_Low stays 0.
// - Assert Reset during bit 10 of status reply -> Data_Out_Low=0 same cycle; all outputs 0.
//   After release, next 8'h01 is answered normally.
// - Buttons change during TURN -> reply carries value at TURN entry.

Source files
------------

// File: rtl/n64_controller_responder.sv
// N64 controller-side responder: decodes host command bytes on the
// single-wire link and replies with the ID word or the button status.
//
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   Data_In      raw pad level (async), 1 = line high/released
//   Data_Out_Low 1 = pull line low (open-drain enable)
//   Buttons      32-bit button status word for the status reply
//   Cmd          last decoded command, valid with Cmd_Valid
//   Cmd_Valid    one-cycle pulse when command + stop decoded
//   Busy         high from first command edge until reply finished
//   Error        one-cycle pulse on a timing abort
module n64_controller_responder #(
    parameter int CLKS_PER_US = 50,
    parameter int TIMEOUT_US  = 8,
    parameter int TURN_US     = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Data_In,
    output logic        Data_Out_Low,
    input  logic [31:0] Buttons,
    output logic [7:0]  Cmd,
    output logic        Cmd_Valid,
    output logic        Busy,
    output logic        Error
);

    localparam int TO_CYC = TIMEOUT_US * CLKS_PER_US;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int BW     = $clog2(2 * CLKS_PER_US + 2);

    localparam logic [TW-1:0] T_TO       = TW'(TO_CYC);
    localparam logic [TW-1:0] T_1US      = TW'(CLKS_PER_US);
    localparam logic [TW-1:0] T_2US      = TW'(2 * CLKS_PER_US);
    localparam logic [TW-1:0] T_3US      = TW'(3 * CLKS_PER_US);
    localparam logic [TW-1:0] T_CELL_END = TW'(4 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] T_TURN_END = TW'(TURN_US * CLKS_PER_US - 1);
    localparam logic [BW-1:0] B_SAMPLE   = BW'(2 * CLKS_PER_US);
    localparam logic [BW-1:0] B_MAX      = BW'(2 * CLKS_PER_US + 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_LOW,
        RX_HIGH,
        RX_STOP,
        TURN,
        TX_BIT,
        TX_STOP
    } state_t;

    state_t state, state_n;

    // Synchronizer resets high so a released line never looks like a fall
    logic s_meta, s, s_d;
    logic fall, rise;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
            s_d    <= 1'b1;
        end else begin
            s_meta <= Data_In;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    assign fall = s_d & ~s;
    assign rise = ~s_d & s;

    // timer: time in current level/phase; btimer: time since bit falling edge
    logic [TW-1:0] timer, timer_n;
    logic [BW-1:0] btimer, btimer_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [31:0]   tx_shift, tx_shift_n;
    logic [4:0]    tx_cnt, tx_cnt_n;
    logic [4:0]    tx_last, tx_last_n;
    logic [7:0]    cmd_n;
    logic          cmd_valid_n, busy_n, error_n, dol_n;
    logic          sample;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            timer        <= '0;
            btimer       <= '0;
            bitcnt       <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_last      <= '0;
            Cmd          <= 8'h00;
            Cmd_Valid    <= 1'b0;
            Busy         <= 1'b0;
            Error        <= 1'b0;
            Data_Out_Low <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            btimer       <= btimer_n;
            bitcnt       <= bitcnt_n;
            rx_shift     <= rx_shift_n;
            tx_shift     <= tx_shift_n;
            tx_cnt       <= tx_cnt_n;
            tx_last      <= tx_last_n;
            Cmd          <= cmd_n;
            Cmd_Valid    <= cmd_valid_n;
            Busy         <= busy_n;
            Error        <= error_n;
            Data_Out_Low <= dol_n;
        end
    end

    // The data point is 2us after the falling edge, whether or not
    // the line has already risen by then.
    assign sample = (btimer == B_SAMPLE);

    always_comb begin
        state_n     = state;
        timer_n     = (timer == T_TO) ? timer : timer + 1'b1;
        btimer_n    = (btimer == B_MAX) ? btimer : btimer + 1'b1;
        bitcnt_n    = bitcnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        tx_cnt_n    = tx_cnt;
        tx_last_n   = tx_last;
        cmd_n       = Cmd;
        cmd_valid_n = 1'b0;
        busy_n      = Busy;
        error_n     = 1'b0;
        dol_n       = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    state_n  = RX_LOW;
                    timer_n  = '0;
                    btimer_n = '0;
                    bitcnt_n = '0;
                    busy_n   = 1'b1;
                end
            end
            RX_LOW, RX_HIGH: begin
                if (sample) begin
                    rx_shift_n = {rx_shift[6:0], s};
                    bitcnt_n   = bitcnt + 1'b1;
                end
                if (state == RX_LOW && rise) begin
                    state_n = RX_HIGH;
                    timer_n = '0;
                end else if (state == RX_HIGH && fall) begin
                    state_n  = (bitcnt < 4'd8) ? RX_LOW : RX_STOP;
                    timer_n  = '0;
                    btimer_n = '0;
                end else if (timer == T_TO) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            RX_STOP: begin
                if (rise) begin
                    cmd_n       = rx_shift;
                    cmd_valid_n = 1'b1;
                    timer_n     = '0;
                    tx_cnt_n    = '0;
                    if (rx_shift == 8'h00 || rx_shift == 8'hFF) begin
                        state_n    = TURN;
                        tx_shift_n = {24'h050002, 8'h00};
                        tx_last_n  = 5'd23;
                    end else if (rx_shift == 8'h01) begin
                        state_n    = TURN;
                        tx_shift_n = Buttons;
                        tx_last_n  = 5'd31;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else if (timer == T_TO) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            TURN: begin
                if (timer == T_TURN_END) begin
                    state_n = TX_BIT;
                    timer_n = '0;
                end
            end
            TX_BIT: begin
                if (timer == T_CELL_END) begin
                    timer_n = '0;
                    if (tx_cnt == tx_last) begin
                        state_n = TX_STOP;
                    end else begin
                        tx_cnt_n   = tx_cnt + 1'b1;
                        tx_shift_n = {tx_shift[30:0], 1'b0};
                    end
                end
            end
            TX_STOP: begin
                // Line is released at T_2US; Busy drops a cycle after
                if (timer == T_2US) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Drive level follows the registered state/timer it lands with
        if (state_n == TX_BIT) begin
            dol_n = timer_n < (tx_shift_n[31] ? T_1US : T_3US);
        end else if (state_n == TX_STOP) begin
            dol_n = timer_n < T_2US;
        end
    end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Randomized bench for n64_controller_responder: acts as host,
// decodes reply pulses off Data_Out_Low and scores against a model.
module tb_n64_controller_responder;

    localparam int CPU  = 4;
    localparam int TURN = 2 * CPU;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Data_In = 1'b1;
    logic        Data_Out_Low;
    logic [31:0] Buttons = '0;
    logic [7:0]  Cmd;
    logic        Cmd_Valid;
    logic        Busy;
    logic        Error;

    int checks = 0;
    int failures = 0;

    n64_controller_responder #(
        .CLKS_PER_US(CPU),
        .TIMEOUT_US (8),
        .TURN_US    (2)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Data_In     (Data_In),
        .Data_Out_Low(Data_Out_Low),
        .Buttons     (Buttons),
        .Cmd         (Cmd),
        .Cmd_Valid   (Cmd_Valid),
        .Busy        (Busy),
        .Error       (Error)
    );

    always #5 clk = ~clk;

    // Line monitor: low-pulse lengths and start cycles, pulse counts
    int   cyc = 0;
    int   lens[$];
    int   starts[$];
    int   low_len = 0;
    logic dol_prev = 1'b0;
    int   cv_cnt = 0;
    int   err_cnt = 0;
    logic [7:0] cv_cmd = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (Data_Out_Low && !dol_prev) begin
            starts.push_back(cyc);
            low_len = 1;
        end else if (Data_Out_Low) begin
            low_len++;
        end else if (dol_prev) begin
            lens.push_back(low_len);
        end
        dol_prev = Data_Out_Low;
        if (Cmd_Valid) begin
            cv_cnt++;
            cv_cmd = Cmd;
        end
        if (Error) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        lens.delete();
        starts.delete();
        cv_cnt  = 0;
        err_cnt = 0;
    endtask

    // One host bit cell: '1' = 1us low, '0' = 3us low, 4us total
    task automatic host_bit(input logic b);
        int lo;
        lo = b ? CPU : 3 * CPU;
        Data_In = 1'b0;
        repeat (lo) tick();
        Data_In = 1'b1;
        repeat (4 * CPU - lo) tick();
    endtask

    // Sends 8-bit command + 1us stop low; returns cycle of stop release
    task automatic host_cmd(input logic [7:0] c, output int rel);
        for (int i = 7; i >= 0; i--) host_bit(c[i]);
        Data_In = 1'b0;
        repeat (CPU) tick();
        Data_In = 1'b1;
        rel = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk({tag, "_busy_timeout"}, 32'd1, 32'd0);
    endtask

    // Reference: what the controller should say to a command
    function automatic int reply_bits(input logic [7:0] c);
        if (c == 8'h00 || c == 8'hFF) return 24;
        if (c == 8'h01) return 32;
        return 0;
    endfunction

    function automatic logic [31:0] reply_val(input logic [7:0] c,
                                              input logic [31:0] b);
        if (c == 8'h01) return b;
        return 32'h0005_0002;
    endfunction

    task automatic transact(input logic [7:0] c, input logic [31:0] b,
                            input logic change);
        int rel, nb, bad, badp, d;
        logic [31:0] val;
        clear_mon();
        Buttons = b;
        host_cmd(c, rel);
        if (change) begin
            repeat (5) tick();
            Buttons = ~b;
        end
        nb = reply_bits(c);
        if (nb == 0) begin
            repeat (4) tick();
            chk("nr_busy", {31'd0, Busy}, 32'd0);
        end
        wait_idle("tx");
        repeat (3) tick();
        chk("cv_cnt", cv_cnt, 1);
        chk("cmd", {24'd0, cv_cmd}, {24'd0, c});
        chk("err", err_cnt, 0);
        chk("n_lows", lens.size(), nb == 0 ? 0 : nb + 1);
        if (nb != 0 && lens.size() == nb + 1 && starts.size() == nb + 1) begin
            val  = '0;
            bad  = 0;
            badp = 0;
            for (int i = 0; i < nb; i++) begin
                if (lens[i] == CPU) val = {val[30:0], 1'b1};
                else if (lens[i] == 3 * CPU) val = {val[30:0], 1'b0};
                else bad++;
            end
            for (int i = 1; i <= nb; i++)
                if (starts[i] - starts[i-1] != 4 * CPU) badp++;
            chk("bit_len", bad, 0);
            chk("reply", val, reply_val(c, b) & ((nb == 32) ? 32'hFFFF_FFFF
                                                           : 32'h00FF_FFFF));
            chk("stop_len", lens[nb], 2 * CPU);
            chk("cell", badp, 0);
            d = starts[0] - rel;
            chk("turn", {31'd0, (d >= TURN && d <= TURN + 5)}, 32'd1);
        end
        Buttons = '0;
        repeat (8) tick();
    endtask

    initial begin
        int rel, r;
        logic [7:0] c;

        repeat (3) tick();
        chk("rst_dol", {31'd0, Data_Out_Low}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_cmd", {24'd0, Cmd}, 32'd0);
        chk("rst_cv_err", {30'd0, Cmd_Valid, Error}, 32'd0);
        Reset = 1'b1;
        repeat (4) tick();

        transact(8'h01, 32'h8000_7F80, 1'b0);
        transact(8'h00, 32'h1234_5678, 1'b0);
        transact(8'hFF, 32'h0, 1'b0);
        transact(8'h40, 32'hFFFF_FFFF, 1'b0);
        transact(8'h01, 32'hA5C3_0F96, 1'b1);

        // Abort after 5 bits, line left high for 10us
        clear_mon();
        for (int i = 0; i < 5; i++) host_bit(1'(i & 1));
        repeat (10 * CPU) tick();
        chk("abort_err", err_cnt, 1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_lows", lens.size() + starts.size(), 0);
        chk("abort_cv", cv_cnt, 0);
        repeat (4) tick();

        // Reset in the middle of reply bit 10 (a '0' of 8000_7F80)
        clear_mon();
        Buttons = 32'h8000_7F80;
        host_cmd(8'h01, rel);
        r = 0;
        while (!(starts.size() == 10 && Data_Out_Low) && r < 2000) begin
            tick();
            r++;
        end
        chk("rst_reach", {31'd0, r < 2000}, 32'd1);
        tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_dol", {31'd0, Data_Out_Low}, 32'd0);
        chk("mid_outs", {Cmd, 21'd0, Cmd_Valid, Busy, Error}, 32'd0);
        repeat (3) tick();
        Reset = 1'b1;
        repeat (4) tick();
        transact(8'h01, 32'h8000_7F80, 1'b0);

        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: c = 8'h00;
                1: c = 8'h01;
                2: c = 8'hFF;
                default: c = 8'($urandom);
            endcase
            transact(c, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
